// File: rtl/mod_pow_seq.sv
// Sequential modular exponentiator: res = a^b mod p via right-to-left
// square-and-multiply over a bit-serial shift-add modular multiplier.
`default_nettype none

module mod_pow_seq #(
    parameter int WIDTH = 128,
    parameter int EW    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [EW-1:0]    b,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             valid,
    output logic             err,
    output logic [WIDTH-1:0] res
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RED  = 3'd2,
        MUL  = 3'd3,
        SQR  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, p_q, r_q, base_q, y_q;
    logic [EW-1:0]    e_q, e_sh;
    logic [WIDTH:0]   acc_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] mm_x, mm_res;
    logic [WIDTH:0]   p_ext, dbl, dbl_red, sum, sum_red, acc_nx;
    logic             last;

    // One multiplier step; acc and x are both < p, so every sum fits WIDTH+1 bits.
    always_comb begin
        mm_x    = (state == MUL) ? r_q : (state == SQR) ? base_q : WIDTH'(1);
        p_ext   = {1'b0, p_q};
        dbl     = {acc_q[WIDTH-1:0], 1'b0};
        dbl_red = (dbl >= p_ext) ? dbl - p_ext : dbl;
        sum     = dbl_red + {1'b0, mm_x};
        sum_red = (sum >= p_ext) ? sum - p_ext : sum;
        acc_nx  = y_q[WIDTH-1] ? sum_red : dbl_red;
        mm_res  = acc_nx[WIDTH-1:0];
        last    = (cnt_q == CW'(WIDTH - 1));
        e_sh    = e_q >> 1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = LOAD;
            LOAD:       state_nx = (p_q <= WIDTH'(1)) ? DONE : RED;
            RED: if (last) begin
                if (e_q == '0)  state_nx = DONE;
                else if (e_q[0]) state_nx = MUL;
                else            state_nx = SQR;
            end
            MUL: if (last) state_nx = (e_sh == '0) ? DONE : SQR;
            SQR: if (last) state_nx = e_sh[0] ? MUL : SQR;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign busy = (state == LOAD) || (state == RED) || (state == MUL) || (state == SQR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            p_q    <= '0;
            r_q    <= '0;
            base_q <= '0;
            y_q    <= '0;
            e_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            res    <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    a_q   <= a;
                    e_q   <= b;
                    p_q   <= p;
                    valid <= 1'b0;
                    err   <= 1'b0;
                end
                LOAD: begin
                    if (p_q <= WIDTH'(1)) begin
                        err   <= (p_q == '0);
                        res   <= '0;
                        valid <= 1'b1;
                    end else begin
                        r_q   <= WIDTH'(1);
                        acc_q <= '0;
                        cnt_q <= '0;
                        y_q   <= a_q;
                    end
                end
                RED, MUL, SQR: begin
                    if (!last) begin
                        acc_q <= acc_nx;
                        y_q   <= y_q << 1;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        // Next multiplier always consumes base, so reload y with it now.
                        if (state == MUL) begin
                            r_q <= mm_res;
                            y_q <= base_q;
                        end else begin
                            base_q <= mm_res;
                            y_q    <= mm_res;
                        end
                        if (state == SQR) e_q <= e_sh;
                        if (state_nx == DONE) begin
                            res   <= (state == MUL) ? mm_res : r_q;
                            valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_pow_seq.sv
// Self-checking bench for mod_pow_seq at WIDTH 8, 16 and 128 against a
// plain-arithmetic reference model.
`default_nettype none

module tb_mod_pow_seq;

    localparam int LIMIT = 3000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   cur = 2'd0;
    logic [127:0] a_in = '0, b_in = '0, p_in = '0;

    logic         bsy8, v8, e8, bsy16, v16, e16, bsy128, v128, e128;
    logic [7:0]   res8;
    logic [15:0]  res16;
    logic [127:0] res128;
    logic         cur_busy, cur_valid, cur_err;
    logic [127:0] cur_res;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mod_pow_seq #(.WIDTH(8), .EW(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start && cur == 2'd0),
        .a(a_in[7:0]), .b(b_in[7:0]), .p(p_in[7:0]),
        .busy(bsy8), .valid(v8), .err(e8), .res(res8));

    mod_pow_seq #(.WIDTH(16), .EW(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start && cur == 2'd1),
        .a(a_in[15:0]), .b(b_in[15:0]), .p(p_in[15:0]),
        .busy(bsy16), .valid(v16), .err(e16), .res(res16));

    mod_pow_seq #(.WIDTH(128), .EW(128)) u_d128 (
        .clk(clk), .rst_n(rst_n), .start(start && cur == 2'd2),
        .a(a_in), .b(b_in), .p(p_in),
        .busy(bsy128), .valid(v128), .err(e128), .res(res128));

    always_comb begin
        cur_busy  = (cur == 2'd0) ? bsy8 : (cur == 2'd1) ? bsy16 : bsy128;
        cur_valid = (cur == 2'd0) ? v8   : (cur == 2'd1) ? v16   : v128;
        cur_err   = (cur == 2'd0) ? e8   : (cur == 2'd1) ? e16   : e128;
        cur_res   = (cur == 2'd0) ? 128'(res8) : (cur == 2'd1) ? 128'(res16) : res128;
    end

    function automatic int cur_w();
        return (cur == 2'd0) ? 8 : (cur == 2'd1) ? 16 : 128;
    endfunction

    function automatic logic [127:0] wmask(input int w);
        logic [127:0] m;
        m = '1;
        return (w >= 128) ? m : (m >> (128 - w));
    endfunction

    function automatic logic [127:0] ref_pow(input logic [127:0] ra, rb, rp);
        logic [255:0] r, base, m;
        if (rp == '0) return '0;
        m    = 256'(rp);
        r    = 256'(1) % m;
        base = 256'(ra) % m;
        for (int i = 0; i < 128; i++) begin
            if (rb[i]) r = (r * base) % m;
            base = (base * base) % m;
        end
        return r[127:0];
    endfunction

    function automatic int ref_lat(input logic [127:0] rb, rp, input int w);
        int n, bl;
        if (rp <= 128'd1) return 2;
        bl = 0;
        for (int i = 0; i < 128; i++) if (rb[i]) bl = i + 1;
        n = $countones(rb) + bl;
        if (n < 1) n = 1;
        return 2 + w * n;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on the selected instance and time it to valid.
    task automatic run(input logic [127:0] ta, tb_, tp, input int intr_at, input int rst_at,
                       output int lat, output logic [127:0] r, output logic e);
        @(negedge clk);
        a_in = ta; b_in = tb_; p_in = tp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk("busy_after_accept", 128'(cur_busy), 128'(1));
        chk("valid_clear_on_accept", 128'(cur_valid), 128'(0));
        while (!cur_valid && lat < LIMIT) begin
            if (lat == intr_at) begin
                a_in = 128'd3; b_in = 128'd5; p_in = 128'd7; start = 1'b1;
            end
            if (lat == rst_at) begin
                rst_n = 1'b0;
                #2;
                chk("async_rst_busy", 128'(cur_busy), 128'(0));
                chk("async_rst_valid", 128'(cur_valid), 128'(0));
                chk("async_rst_err", 128'(cur_err), 128'(0));
                chk("async_rst_res", cur_res, 128'(0));
                @(negedge clk);
                rst_n = 1'b1;
                r = '0; e = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk("valid_before_timeout", 128'(cur_valid), 128'(1));
        r = cur_res;
        e = cur_err;
    endtask

    task automatic expect_op(input string tag, input logic [127:0] ta, tb_, tp, input int intr_at);
        int lat;
        logic [127:0] r, m;
        logic e;
        m = wmask(cur_w());
        run(ta & m, tb_ & m, tp & m, intr_at, 0, lat, r, e);
        chk({tag, "_res"}, r, ref_pow(ta & m, tb_ & m, tp & m));
        chk({tag, "_err"}, 128'(e), 128'((tp & m) == '0));
        chk({tag, "_lat"}, 128'(lat), 128'(ref_lat(tb_ & m, tp & m, cur_w())));
    endtask

    initial begin
        int lat;
        logic [127:0] r, ra, rb, rp;
        logic e;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(bsy8), 128'(0));
        chk("rst_valid", 128'(v8), 128'(0));
        chk("rst_err", 128'(e8), 128'(0));
        chk("rst_res128", res128, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        cur = 2'd2;
        expect_op("w128_25_23_18", 128'd25, 128'd23, 128'd18, 0);
        chk("w128_const_res", cur_res, 128'd13);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            chk("w128_hold", {cur_valid, cur_res[126:0]}, {1'b1, 127'd13});
        end

        cur = 2'd0;
        expect_op("w8_255_255_251", 128'd255, 128'd255, 128'd251, 0);
        chk("w8_const_res", cur_res, 128'd20);
        expect_op("w8_b0", 128'd5, 128'd0, 128'd7, 0);
        expect_op("w8_p0", 128'd5, 128'd0, 128'd0, 0);
        expect_op("w8_p1", 128'd9, 128'd3, 128'd1, 0);
        expect_op("w8_ignored_restart", 128'd255, 128'd255, 128'd251, 30);

        // Abort during the first squaring pass, then recover.
        run(128'd255, 128'd255, 128'd251, 0, 20, lat, r, e);
        expect_op("w8_after_reset", 128'd200, 128'd77, 128'd199, 0);

        cur = 2'd1;
        for (int i = 0; i < 200; i++) begin
            ra = 128'($urandom_range(0, 65535));
            rp = 128'($urandom_range(2, 65535));
            rb = 128'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            expect_op("w16_rand", ra, rb, rp, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
